// File: rtl/sa_pkg.sv
// Shared types for the systolic-array output stage.
package sa_pkg;

    // Deskew/write controller states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sa_state_e;

    // Default partial-sum element width and its element type.
    localparam int unsigned PSUM_WIDTH = 32;
    typedef logic [PSUM_WIDTH-1:0] psum_t;

    // Row address width; a single-row memory still gets a 1-bit address.
    function automatic int unsigned addr_width(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/sa_output_deskew_if.sv
// Output memory write port: active-low chip/write enable, row address, packed row data.
interface sa_output_deskew_if
    import sa_pkg::*;
#(
    parameter int unsigned ADD_DATAWIDTH = 32,
    parameter int unsigned NUM_COLS      = 4,
    parameter int unsigned MEM_ROWS      = 8
);

    localparam int unsigned ADDR_WIDTH = addr_width(MEM_ROWS);

    logic                              o_cenb;
    logic                              o_wenb;
    logic [ADDR_WIDTH-1:0]             o_addr;
    logic [ADD_DATAWIDTH*NUM_COLS-1:0] o_data;

    modport master (
        output o_cenb,
        output o_wenb,
        output o_addr,
        output o_data
    );

    modport slave (
        input o_cenb,
        input o_wenb,
        input o_addr,
        input o_data
    );

endinterface

// File: rtl/sa_delay_line.sv
// DEPTH x WIDTH register chain with async reset; DEPTH=0 is a plain wire.
module sa_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        // Clock and reset are not needed for a zero-stage line.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign dout = din;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift din through DEPTH stages; reset clears every stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign dout = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/sa_output_deskew.sv
// Re-aligns column-skewed array outputs and writes each row as one packed memory word.
module sa_output_deskew
    import sa_pkg::*;
#(
    parameter int unsigned ADD_DATAWIDTH = 32,
    parameter int unsigned NUM_COLS      = 4,
    parameter int unsigned MEM_ROWS      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_valid,
    input  logic [ADD_DATAWIDTH-1:0] i_psum [NUM_COLS],
    sa_output_deskew_if.master       mem,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overflow
);

    localparam int unsigned ADDR_WIDTH = addr_width(MEM_ROWS);
    localparam int unsigned CNT_WIDTH  = $clog2(MEM_ROWS + 1);
    localparam int unsigned ROW_WIDTH  = ADD_DATAWIDTH * NUM_COLS;

    localparam logic [CNT_WIDTH-1:0] LAST_ACCEPT = CNT_WIDTH'(MEM_ROWS - 1);
    localparam logic [CNT_WIDTH-1:0] ALL_ROWS    = CNT_WIDTH'(MEM_ROWS);

    sa_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]     acc_cnt_q;
    logic [CNT_WIDTH-1:0]     wr_cnt_q;
    logic                     overflow_q;
    logic                     wr_en_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [ROW_WIDTH-1:0]     data_q;

    logic                     accept;
    logic                     drop;
    logic                     start_job;
    logic                     token_aligned;
    logic [ADD_DATAWIDTH-1:0] aligned [NUM_COLS];
    logic [ROW_WIDTH-1:0]     row_packed;

    // Only RUN admits tokens; IDLE and DONE silently ignore i_valid.
    assign accept    = (state_q == StRun) && i_valid;
    assign drop      = (state_q == StDrain) && i_valid;
    assign start_job = (state_q == StIdle) && i_start;

    // Column j arrives j cycles late, so it is delayed NUM_COLS-1-j to line up with the last one.
    for (genvar j = 0; j < int'(NUM_COLS); j++) begin : g_col
        sa_delay_line #(
            .DEPTH (NUM_COLS - 1 - j),
            .WIDTH (ADD_DATAWIDTH)
        ) u_col_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (i_psum[j]),
            .dout  (aligned[j])
        );
    end

    sa_delay_line #(
        .DEPTH (NUM_COLS - 1),
        .WIDTH (1)
    ) u_token_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (accept),
        .dout  (token_aligned)
    );

    // Pack the aligned row with column 0 in the most significant slice.
    always_comb begin
        row_packed = '0;
        for (int j = 0; j < int'(NUM_COLS); j++) begin
            row_packed[(int'(NUM_COLS) - 1 - j) * int'(ADD_DATAWIDTH) +: ADD_DATAWIDTH] =
                aligned[j];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DRAIN ends once every accepted row has been issued to memory.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StRun;
            StRun:   if (accept && (acc_cnt_q == LAST_ACCEPT)) state_d = StDrain;
            StDrain: if (wr_cnt_q == ALL_ROWS) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_busy = (state_q == StRun) || (state_q == StDrain);
        o_done = (state_q == StDone);
    end

    // Job counters and sticky overflow; a taken start clears all three.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else if (start_job) begin
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                acc_cnt_q <= acc_cnt_q + 1'b1;
            end
            if (token_aligned && (wr_cnt_q != ALL_ROWS)) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Register the aligned row; address and data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= token_aligned;
            if (token_aligned) begin
                addr_q <= wr_cnt_q[ADDR_WIDTH-1:0];
                data_q <= row_packed;
            end
        end
    end

    assign mem.o_cenb = ~wr_en_q;
    assign mem.o_wenb = ~wr_en_q;
    assign mem.o_addr = addr_q;
    assign mem.o_data = data_q;
    assign o_overflow = overflow_q;

endmodule
